// File: rtl/macro_credit_arb4_decr3.sv
// Four-requester round-robin arbiter with per-requester 3-bit credit counters.
// Every grant consumes one credit through the single shared decrementer.

module macro_rom_decr3 (
    input  logic [2:0] d,
    output logic [2:0] q,
    output logic       c
);
    always_comb begin
        q = 3'd0;
        c = 1'b0;
        case (d)
            3'd0: begin q = 3'd7; c = 1'b1; end
            3'd1: q = 3'd0;
            3'd2: q = 3'd1;
            3'd3: q = 3'd2;
            3'd4: q = 3'd3;
            3'd5: q = 3'd4;
            3'd6: q = 3'd5;
            3'd7: q = 3'd6;
            default: begin q = 3'd0; c = 1'b0; end
        endcase
    end
endmodule

module macro_credit_arb4_decr3 #(
    parameter logic [2:0] INIT_CREDIT = 3'd7
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  req,
    input  logic [3:0]  rtn,
    output logic [3:0]  gnt,
    output logic        gnt_valid,
    output logic [1:0]  gnt_id,
    output logic [11:0] credit,
    output logic        err_ovf,
    output logic        err_udf
);
    logic [2:0] r_credit [4];
    logic [1:0] r_rr_ptr;
    logic [3:0] r_gnt;
    logic       r_gnt_valid;
    logic [1:0] r_gnt_id;
    logic       r_err_ovf;
    logic       r_err_udf;

    logic [3:0] w_elig;
    logic       w_win_vld;
    logic [1:0] w_win_id;
    logic [2:0] w_dec_d;
    logic [2:0] w_dec_q;
    logic       w_dec_c;
    logic [3:0] w_dec_sel;
    logic [2:0] w_inc_q    [4];
    logic [2:0] w_credit_nxt [4];
    logic       w_ovf_set;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_elig[i]  = req[i] && (r_credit[i] != 3'd0);
            w_inc_q[i] = r_credit[i] + 3'd1;
        end
    end

    // Round-robin search starting at the pointer; the first eligible index wins.
    always_comb begin
        w_win_vld = 1'b0;
        w_win_id  = r_rr_ptr;
        for (int k = 0; k < 4; k++) begin
            if (!w_win_vld && w_elig[r_rr_ptr + 2'(k)]) begin
                w_win_vld = 1'b1;
                w_win_id  = r_rr_ptr + 2'(k);
            end
        end
    end

    assign w_dec_d = r_credit[w_win_id];

    macro_rom_decr3 u_decr (
        .d (w_dec_d),
        .q (w_dec_q),
        .c (w_dec_c)
    );

    // A borrow from the decrementer leaves the winner's credit untouched.
    assign w_dec_sel = (w_win_vld && !w_dec_c) ? (4'b0001 << w_win_id) : 4'b0000;

    always_comb begin
        w_ovf_set = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_credit_nxt[i] = r_credit[i];
            if (rtn[i] && !w_dec_sel[i]) begin
                if (r_credit[i] == 3'd7) begin
                    w_ovf_set = 1'b1;
                end else begin
                    w_credit_nxt[i] = w_inc_q[i];
                end
            end else if (!rtn[i] && w_dec_sel[i]) begin
                w_credit_nxt[i] = w_dec_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_gnt       <= 4'b0000;
            r_gnt_valid <= 1'b0;
            r_gnt_id    <= 2'd0;
            r_rr_ptr    <= 2'd0;
            r_err_ovf   <= 1'b0;
            r_err_udf   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_credit[i] <= INIT_CREDIT;
            end
        end else begin
            r_gnt       <= w_win_vld ? (4'b0001 << w_win_id) : 4'b0000;
            r_gnt_valid <= w_win_vld;
            if (w_win_vld) begin
                r_gnt_id <= w_win_id;
                r_rr_ptr <= w_win_id + 2'd1;
            end
            for (int i = 0; i < 4; i++) begin
                r_credit[i] <= w_credit_nxt[i];
            end
            if (w_ovf_set) begin
                r_err_ovf <= 1'b1;
            end
            if (w_win_vld && w_dec_c) begin
                r_err_udf <= 1'b1;
            end
        end
    end

    assign gnt       = r_gnt;
    assign gnt_valid = r_gnt_valid;
    assign gnt_id    = r_gnt_id;
    assign credit    = {r_credit[3], r_credit[2], r_credit[1], r_credit[0]};
    assign err_ovf   = r_err_ovf;
    assign err_udf   = r_err_udf;
endmodule

// File: tb/tb_macro_credit_arb4_decr3.sv
// Bench for macro_credit_arb4_decr3: directed scenarios plus random traffic
// compared every cycle against an arithmetic credit/arbitration model.

module tb_macro_credit_arb4_decr3;
    localparam int INIT = 7;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  req;
    logic [3:0]  rtn;
    logic [3:0]  gnt;
    logic        gnt_valid;
    logic [1:0]  gnt_id;
    logic [11:0] credit;
    logic        err_ovf;
    logic        err_udf;

    int n_checks = 0;
    int n_fail   = 0;

    int m_cr [4];
    int m_ptr, m_gnt, m_vld, m_id, m_ovf, m_udf;

    macro_credit_arb4_decr3 #(.INIT_CREDIT(3'd7)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req       (req),
        .rtn       (rtn),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .credit    (credit),
        .err_ovf   (err_ovf),
        .err_udf   (err_udf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural model: credits are plain integers, a grant subtracts one,
    // a return adds one, and anything above 7 clips back to 7 with an error.
    task automatic model_update(input logic rn, input logic [3:0] rq, input logic [3:0] rt);
        int w;
        int n;
        int idx;
        if (!rn) begin
            for (int i = 0; i < 4; i++) m_cr[i] = INIT;
            m_ptr = 0; m_gnt = 0; m_vld = 0; m_id = 0; m_ovf = 0; m_udf = 0;
        end else begin
            w = -1;
            for (int k = 0; k < 4; k++) begin
                idx = (m_ptr + k) % 4;
                if (w < 0 && rq[idx] && m_cr[idx] > 0) w = idx;
            end
            if (w >= 0) begin
                m_gnt = 1 << w; m_vld = 1; m_id = w; m_ptr = (w + 1) % 4;
            end else begin
                m_gnt = 0; m_vld = 0;
            end
            for (int i = 0; i < 4; i++) begin
                n = m_cr[i] + int'(rt[i]) - ((w == i) ? 1 : 0);
                if (n > 7) begin
                    n = 7;
                    m_ovf = 1;
                end
                m_cr[i] = n;
            end
        end
    endtask

    function automatic logic [11:0] model_credit();
        logic [11:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) v[3*i +: 3] = 3'(m_cr[i]);
        return v;
    endfunction

    task automatic step(input logic rn, input logic [3:0] rq, input logic [3:0] rt);
        resetn = rn;
        req    = rq;
        rtn    = rt;
        @(posedge clk);
        model_update(rn, rq, rt);
        #1;
        check_eq("gnt",       gnt,       m_gnt);
        check_eq("gnt_valid", gnt_valid, m_vld);
        check_eq("gnt_id",    gnt_id,    m_id);
        check_eq("credit",    credit,    model_credit());
        check_eq("err_ovf",   err_ovf,   m_ovf);
        check_eq("err_udf",   err_udf,   m_udf);
    endtask

    logic [3:0] rr_seq [8];

    initial begin
        resetn = 1'b0;
        req    = 4'b0000;
        rtn    = 4'b0000;
        for (int i = 0; i < 4; i++) m_cr[i] = INIT;
        m_ptr = 0; m_gnt = 0; m_vld = 0; m_id = 0; m_ovf = 0; m_udf = 0;

        // Reset state
        step(1'b0, 4'b0000, 4'b0000);
        step(1'b0, 4'b0000, 4'b0000);
        check_eq("rst_gnt",    gnt,       4'b0000);
        check_eq("rst_vld",    gnt_valid, 1'b0);
        check_eq("rst_credit", credit,    12'o7777);
        check_eq("rst_ovf",    err_ovf,   1'b0);
        check_eq("rst_udf",    err_udf,   1'b0);

        // All four requesting: strict rotation, two credits taken from each
        rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int c = 0; c < 8; c++) begin
            step(1'b1, 4'b1111, 4'b0000);
            check_eq("rr_seq", gnt, rr_seq[c]);
        end
        step(1'b1, 4'b0000, 4'b0000);
        check_eq("rr_credit", credit, 12'o5555);

        // Single requester drains its credit then stops being granted
        step(1'b0, 4'b0000, 4'b0000);
        for (int c = 0; c < 9; c++) begin
            step(1'b1, 4'b0001, 4'b0000);
            check_eq("drain_gnt", gnt, (c < 7) ? 4'b0001 : 4'b0000);
        end
        check_eq("drain_c0",  credit[2:0], 3'd0);
        check_eq("drain_udf", err_udf,     1'b0);

        // One return re-enables the starved requester for exactly one grant
        step(1'b1, 4'b0001, 4'b0001);
        check_eq("ret_nogrant", gnt,         4'b0000);
        check_eq("ret_c0_one",  credit[2:0], 3'd1);
        step(1'b1, 4'b0001, 4'b0000);
        check_eq("ret_grant",   gnt,         4'b0001);
        check_eq("ret_c0_zero", credit[2:0], 3'd0);
        step(1'b1, 4'b0001, 4'b0000);
        check_eq("ret_idle",    gnt,         4'b0000);

        // Grant and return on the same requester cancel out
        step(1'b0, 4'b0000, 4'b0000);
        for (int c = 0; c < 4; c++) step(1'b1, 4'b0100, 4'b0000);
        step(1'b1, 4'b0000, 4'b0000);
        check_eq("c2_three", credit[8:6], 3'd3);
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 4'b0100, 4'b0100);
            check_eq("net0_gnt", gnt,        4'b0100);
            check_eq("net0_c2",  credit[8:6], 3'd3);
        end

        // Return into a full counter saturates and raises a sticky error
        step(1'b0, 4'b0000, 4'b0000);
        step(1'b1, 4'b0000, 4'b1000);
        check_eq("ovf_c3",  credit[11:9], 3'd7);
        check_eq("ovf_set", err_ovf,      1'b1);
        for (int c = 0; c < 3; c++) step(1'b1, 4'b0000, 4'b0000);
        check_eq("ovf_sticky", err_ovf, 1'b1);
        step(1'b0, 4'b0000, 4'b0000);
        check_eq("ovf_clr",    err_ovf, 1'b0);
        check_eq("ovf_credit", credit,  12'o7777);

        // Full-credit grant with same-cycle return: no overflow
        step(1'b1, 4'b0010, 4'b0010);
        check_eq("full_net0_ovf", err_ovf, 1'b0);
        check_eq("full_net0_c1",  credit[5:3], 3'd7);

        // Randomized traffic, including occasional mid-stream resets
        for (int c = 0; c < 600; c++) begin
            step($urandom_range(0, 63) != 0, 4'($urandom), 4'($urandom & $urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/macro_credit_arb4_decr3.md
Name: macro_credit_arb4_decr3

Overview:
- 4-requester round-robin arbiter that shares one 3-bit credit-decrement datapath: a single macro_rom_decr3 instance.
- Each requester owns a 3-bit credit counter. A grant consumes one credit through the shared decrementer. Per-requester return pulses restore credits.
- Sits in front of shared small-depth resources (e.g. 7-entry buffers, outstanding-transaction slots) to throttle requesters against downstream capacity.

Parameters:
- INIT_CREDIT, 3'd7, credit value loaded into every counter at reset. Legal range 0..7.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- resetn  input  1  synchronous active-low reset.
- req  input  4  per-requester request, level; sampled every cycle.
- rtn  input  4  per-requester credit return pulse; one credit per asserted bit per cycle.
- gnt  output  4  registered one-hot grant; pulse is one cycle wide.
- gnt_valid  output  1  registered; equals |gnt.
- gnt_id  output  2  registered index of the granted requester; holds its last value when gnt_valid=0.
- credit  output  12  current credits {c3,c2,c1,c0}, 3 bits each, registered.
- err_ovf  output  1  sticky: a return was applied to a counter already at 7.
- err_udf  output  1  sticky: the shared decrementer borrow output c asserted.

Behaviour:
- Reset (resetn=0 at a clk edge): gnt=0, gnt_valid=0, gnt_id=0, rr_ptr=0, all credits=INIT_CREDIT, err_ovf=0, err_udf=0. Reset overrides req and rtn in the same cycle.
- Eligibility: elig[i] = req[i] & (credit_i != 0). A zero-credit requester is never granted.
- Arbitration (combinational, in cycle N):
  - Search elig starting at rr_ptr, in order rr_ptr, rr_ptr+1, ... mod 4; the first eligible index is the winner.
  - No eligible requester: no grant; rr_ptr and credits unchanged, except for returns.
- Edge ending cycle N, with a winner w:
  - gnt <= 1<<w, gnt_valid <= 1, gnt_id <= w, rr_ptr <= (w+1) mod 4.
  - Latency: req high in cycle N gives gnt high in cycle N+1.
- Shared decrementer:
  - The single decr3 instance takes d = credit_w (the muxed winner credit).
  - Its q is written back to credit_w on the same edge. No other counter is decremented that cycle.
  - At most one decrement per cycle.
- Returns: every i with rtn[i]=1 adds 1 to credit_i on the same edge, via a separate 3-bit incrementer per counter.
- Simultaneous grant and return on the same i: net credit_i unchanged.
- Saturation:
  - Return with credit_i=7 and no simultaneous grant on i: credit stays 7; err_ovf <= 1.
  - With a simultaneous grant on i, the net change is 0, so there is no overflow.
- Underflow: the decrementer is only ever driven with nonzero credit, so c must stay 0. If c=1 while a winner is selected, set err_udf <= 1 and leave the credit unchanged.
- Error flags: err_ovf and err_udf clear only on reset.
- rr_ptr wrap: after a grant to requester 3, the pointer returns to 0.
- Continuous req with credit: the same requester is granted every cycle until its credit reaches 0, provided no other requester is eligible.
- Reset mid-stream: an outstanding grant pulse is dropped. Credits return to INIT_CREDIT regardless of in-flight returns.

Test Plan:
- Reset with INIT_CREDIT=7, req=4'b0000 -> gnt=0, gnt_valid=0, credit=12'o7777, both err flags 0.
- req=4'b1111 held for 8 cycles, no rtn -> gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000 starting one cycle after req; credit=12'o5555.
- req=4'b0001 held for 9 cycles, no rtn -> requester 0 granted 7 consecutive cycles, then gnt=0; c0=0, err_udf=0.
- With c0=0 and req[0] held, pulse rtn[0] once -> gnt=0001 appears two cycles after the rtn edge (credit 1, then grant); c0 ends at 0.
- With c2=3, hold req=4'b0100 and rtn=4'b0100 for 4 cycles -> gnt[2] every cycle; c2 stays 3.
- With all credits at 7, pulse rtn=4'b1000 -> c3 stays 7, err_ovf=1 and stays set; assert resetn=0 -> err_ovf=0 and all credits=7.
